// File: rtl/rand_byte_uart_tx.sv
// Buffers single-cycle random bytes in a small FIFO and sends them on a UART line (8N1, LSB first).
// Define UART_PARITY_EN to add an even-parity bit (8E1 frames).
module rand_byte_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byte_ready,
    input  logic [7:0]                    rand_byte,
    input  logic                          tx_enable,
    input  logic                          overflow_clr,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx, r_busy;
`ifdef UART_PARITY_EN
    logic            r_par;
`endif

    logic w_pop, w_push, w_baud_end;

    // A full FIFO still takes a byte when the head leaves at the same edge.
    assign w_pop      = (r_state == S_IDLE) && tx_enable && (r_count != '0);
    assign w_push     = byte_ready && ((r_count != CW'(FIFO_DEPTH)) || w_pop);
    assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= rand_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (byte_ready && !w_push) r_overflow <= 1'b1;
            else if (overflow_clr)     r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd];
`ifdef UART_PARITY_EN
                        r_par   <= ^r_mem[r_rd];
`endif
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            // Shift register always presents the current bit at [0].
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_rand_byte_uart_tx.sv
// Randomised bench: cycle-level frame model for line/flags, plus a UART receiver feeding a byte scoreboard.
module tb_rand_byte_uart_tx;
    localparam int C = 4;
    localparam int D = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME = 11 * C;
`else
    localparam int FRAME = 10 * C;
`endif

    logic       clk = 1'b0;
    logic       rst, br, en, clr;
    logic [7:0] rb;
    logic       tx, busy, ovf;
    logic [2:0] cnt;

    always #5 clk = ~clk;

    rand_byte_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .byte_ready(br), .rand_byte(rb), .tx_enable(en),
        .overflow_clr(clr), .tx(tx), .busy(busy), .fifo_count(cnt), .overflow(ovf)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: pending bytes, remaining clocks of the frame on the wire, current byte.
    logic [7:0] mq[$];
    logic [7:0] sbq[$];
    int         bcnt = 0;
    logic [7:0] cur = 8'h00;
    logic       movf = 1'b0;
    logic       rx_act = 1'b0;

    function automatic logic exp_tx();
        int k, b;
        if (bcnt == 0) return 1'b1;
        k = FRAME - bcnt;
        b = k / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
`ifdef UART_PARITY_EN
        if (b == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            sbq.delete();
            bcnt = 0;
            movf = 1'b0;
        end else begin
            logic pop;
            pop = (bcnt == 0) && en && (mq.size() > 0);
            if (bcnt > 0) bcnt--;
            if (pop) begin
                cur  = mq.pop_front();
                bcnt = FRAME;
            end
            if (br && mq.size() < D) begin
                mq.push_back(rb);
                sbq.push_back(rb);
            end else if (br) begin
                movf = 1'b1;
            end else if (clr) begin
                movf = 1'b0;
            end
        end
        check("tx", tx, exp_tx());
        check("busy", busy, int'(bcnt > 0));
        check("fifo_count", cnt, mq.size());
        check("overflow", ovf, movf);
    end

    // UART receiver monitor: decodes frames from the line and checks them against the scoreboard.
    initial begin : rx_mon
        int rc, b;
        logic [7:0] rd, e;
        rd = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (tx == 1'b0) begin
                    rx_act = 1'b1;
                    rc = 0;
                end
            end else begin
                rc++;
                if (rc % C == C / 2) begin
                    b = rc / C;
                    if (b >= 1 && b <= 8) rd[b-1] = tx;
`ifdef UART_PARITY_EN
                    if (b == 9) check("rx_parity", tx, ^rd);
`endif
                    if (b == FRAME / C - 1) begin
                        check("rx_stop_bit", tx, 1);
                        if (sbq.size() == 0) begin
                            check("rx_unexpected_frame", rd, -1);
                        end else begin
                            e = sbq.pop_front();
                            check("rx_byte", rd, e);
                        end
                        rx_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step_in(input logic b, input logic [7:0] v);
        @(negedge clk);
        br = b;
        rb = v;
    endtask

    task automatic idle(input int n);
        repeat (n) step_in(1'b0, 8'h00);
    endtask

    initial begin
        int guard;
        rst = 1'b1; br = 1'b0; en = 1'b1; clr = 1'b0; rb = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single byte, then two back-to-back extremes.
        step_in(1'b1, 8'hA5);
        idle(FRAME + 10);
        step_in(1'b1, 8'h00);
        step_in(1'b1, 8'hFF);
        idle(2 * FRAME + 10);

        // Fill while disabled (overflow), then enable with a push on the popping edge.
        @(negedge clk); en = 1'b0;
        for (int i = 1; i <= 6; i++) step_in(1'b1, 8'(i));
        idle(10);
        @(negedge clk); en = 1'b1; br = 1'b1; rb = 8'h77;
        idle(30);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        idle(5 * FRAME + 20);

        // Parity-interesting bytes; drop and clear on the same edge.
        @(negedge clk); en = 1'b0;
        step_in(1'b1, 8'h03);
        step_in(1'b1, 8'h07);
        step_in(1'b1, 8'h10);
        step_in(1'b1, 8'h20);
        @(negedge clk); br = 1'b1; rb = 8'h99; clr = 1'b1;
        @(negedge clk); br = 1'b0; clr = 1'b0; en = 1'b1;
        idle(4 * FRAME + 20);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;

        // Random traffic with enable and clear jitter.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            br  = ($urandom_range(0, 3) == 0);
            rb  = 8'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk); br = 1'b0; en = 1'b1; clr = 1'b0;
        idle(D * (FRAME + 1) + 10);

        // Reset in the middle of a data bit with two bytes still queued.
        step_in(1'b1, 8'h5A);
        step_in(1'b1, 8'h11);
        step_in(1'b1, 8'h22);
        idle(15);
        @(negedge clk); rst = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", cnt, 0);
        check("rst_overflow", ovf, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(FRAME + 20);

        guard = 0;
        while ((mq.size() > 0 || bcnt > 0 || rx_act) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", int'(guard < 3000), 1);
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rand_byte_uart_tx.md
Name: rand_byte_uart_tx

Overview:
Downstream consumer of the TRNG bit collector. Accepts single-cycle byte_ready/rand_byte pulses into a small synchronous FIFO. Serialises the buffered bytes on a UART line, 8N1, LSB first, so an external host can capture the random stream. Sits between the collector and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
FIFO_DEPTH, 16, byte entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
byte_ready  input  1  single-cycle strobe: rand_byte valid this cycle
rand_byte  input  8  byte from collector
tx_enable  input  1  high: new frames may start; low: finish current frame, then hold idle
overflow_clr  input  1  clears sticky overflow flag
tx  output  1  UART serial line, idle high
busy  output  1  high whenever FSM is not IDLE
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky: a byte was dropped because FIFO was full

Behaviour:
- Reset (async, any time, including mid-frame): tx=1, busy=0, fifo_count=0, overflow=0. FIFO pointers cleared. FSM=IDLE. Bit and baud counters = 0. Partial frame is abandoned.
- FIFO push: at an edge where byte_ready=1. Accepted if count<FIFO_DEPTH, or if a pop happens at the same edge. Otherwise the byte is dropped and overflow<=1.
- Simultaneous push+pop: count unchanged; data order preserved.
- overflow: cleared by overflow_clr=1. If a drop and overflow_clr occur at the same edge, set wins (overflow=1).
- Pop: only in IDLE, when tx_enable=1 and count>0. The head byte is loaded into the shift register, the FSM goes to START, and tx<=0 at that same edge.
- Latency: a byte pushed into an empty FIFO at edge E, with FSM idle and enabled, pops at edge E+1. tx falls after edge E+1.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index counts 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1, reloads 0 on each state/bit change. No fractional baud.
- Frame length is exactly 10*CLKS_PER_BIT clocks from tx falling edge to end of stop bit.
- Back-to-back frames: exactly one idle clock (IDLE state, tx=1) between the end of STOP and the next start bit.
- tx is driven from a register; no combinational path from inputs to tx.
- tx_enable low mid-frame: the current frame completes normally. No new pop until tx_enable=1. The FIFO keeps accepting pushes.
- busy=1 in START/DATA/PARITY/STOP, and 0 in IDLE.
- fifo_count reflects the registered occupancy after each edge.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: adds a PARITY state after DATA. It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame becomes 8E1, 11*CLKS_PER_BIT clocks.
- Undefined: no PARITY state, frame is 8N1, and no parity logic is present.

Test Plan:
1. CLKS_PER_BIT=4, FIFO_DEPTH=4. Single byte_ready with 0xA5 -> tx low 4 clk, then bits 1,0,1,0,0,1,0,1 (4 clk each), then high 4 clk. busy high for 40 clk. fifo_count goes 1 then 0 one edge later.
2. Pushes of 0x00 then 0xFF on consecutive cycles -> two frames in order. Exactly 1 idle clock between them. Data bits all 0, then all 1.
3. tx_enable=0, six byte_ready pulses 0x01..0x06 -> fifo_count=4, overflow=1, tx stays 1. Then tx_enable=1 -> frames 0x01..0x04 only. Then overflow_clr -> overflow=0.
4. While FIFO is full and a pop occurs, byte_ready 0x77 at the same edge -> accepted, fifo_count stays 4, overflow unchanged. 0x77 is later sent last.
5. Assert rst in DATA bit 3 of 0x5A with 2 bytes queued -> tx=1, busy=0, fifo_count=0 immediately. After release, no frame is sent.
6. With UART_PARITY_EN defined: 0x03 -> parity bit 0; 0x07 -> parity bit 1. Frame is 44 clk. Drop and overflow_clr on the same edge -> overflow=1.
